div_ctrl_fsm: RTL and testbench

- Sequencing controller for the unsigned restoring-division datapath.
- Sits directly upstream of the quotient (Q) left-shift register and the accumulator (A) / divisor (M) registers, and drives all of their control strobes.
- Accepts a start request, runs WIDTH shift/subtract/test iterations, decides each quotient bit from the sign of the trial remainder, and signals completion or divide-by-zero.

---
 rtl/div_ctrl_fsm.sv | 112 +++++++++++
 tb/tb_div_ctrl_fsm.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl_fsm.sv
// Sequencing controller for an unsigned restoring divider: drives the A/M/Q
// register strobes through LOAD, then WIDTH rounds of SHIFT_A/SUB/TEST, then DONE.
module div_ctrl_fsm #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_divisor_zero,
  input  logic i_a_msb,
  output logic o_clr_a,
  output logic o_ld_m,
  output logic o_en_q,
  output logic o_shl_q,
  output logic o_sl_q,
  output logic o_shl_a,
  output logic o_sub_a,
  output logic o_add_a,
  output logic o_busy,
  output logic o_done,
  output logic o_dbz
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT_A,
    S_SUB,
    S_TEST,
    S_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             dbz_reg, dbz_next;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      dbz_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      dbz_reg   <= dbz_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dbz_next   = dbz_reg;
    o_clr_a    = 1'b0;
    o_ld_m     = 1'b0;
    o_en_q     = 1'b0;
    o_shl_q    = 1'b0;
    o_sl_q     = 1'b0;
    o_shl_a    = 1'b0;
    o_sub_a    = 1'b0;
    o_add_a    = 1'b0;
    o_done     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // A zero divisor skips the datapath entirely and reports straight away.
        if (i_start) begin
          if (i_divisor_zero) begin
            state_next = S_DONE;
            dbz_next   = 1'b1;
          end else begin
            state_next = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        o_clr_a    = 1'b1;
        o_ld_m     = 1'b1;
        o_en_q     = 1'b1;
        cnt_next   = CNT_W'(WIDTH);
        dbz_next   = 1'b0;
        state_next = S_SHIFT_A;
      end
      S_SHIFT_A: begin
        o_shl_a    = 1'b1;
        state_next = S_SUB;
      end
      S_SUB: begin
        o_sub_a    = 1'b1;
        state_next = S_TEST;
      end
      S_TEST: begin
        // Negative trial remainder: restore A and shift a 0 into the quotient.
        o_shl_q    = 1'b1;
        o_add_a    = i_a_msb;
        o_sl_q     = ~i_a_msb;
        cnt_next   = cnt_reg - CNT_W'(1);
        state_next = (cnt_reg == CNT_W'(1)) ? S_DONE : S_SHIFT_A;
      end
      S_DONE: begin
        o_done     = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign o_busy = (state_reg != S_IDLE);
  assign o_dbz  = dbz_reg;

endmodule

// File: tb/tb_div_ctrl_fsm.sv
// Testbench for div_ctrl_fsm: a small A/M/Q datapath closes the loop for real
// divisions, and a run-position model predicts every output cycle by cycle.
module tb_div_ctrl_fsm;
  localparam int WIDTH = 4;
  localparam int LAST  = 3 * WIDTH + 1;

  logic i_clk = 1'b0;
  logic i_rst, i_start, i_divisor_zero, i_a_msb;
  logic o_clr_a, o_ld_m, o_en_q, o_shl_q, o_sl_q, o_shl_a, o_sub_a, o_add_a;
  logic o_busy, o_done, o_dbz;

  int total = 0;
  int bad   = 0;

  logic             use_dp;
  logic             msb_drv;
  logic [WIDTH:0]   dp_a;
  logic [WIDTH-1:0] dp_q, dp_m, dividend_bus, divisor_bus;
  logic [10:0]      outs;

  div_ctrl_fsm #(.WIDTH(WIDTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_divisor_zero(i_divisor_zero), .i_a_msb(i_a_msb),
    .o_clr_a(o_clr_a), .o_ld_m(o_ld_m), .o_en_q(o_en_q), .o_shl_q(o_shl_q),
    .o_sl_q(o_sl_q), .o_shl_a(o_shl_a), .o_sub_a(o_sub_a), .o_add_a(o_add_a),
    .o_busy(o_busy), .o_done(o_done), .o_dbz(o_dbz)
  );

  always #5 i_clk = ~i_clk;

  assign i_a_msb = use_dp ? dp_a[WIDTH] : msb_drv;
  assign outs = {o_clr_a, o_ld_m, o_en_q, o_shl_q, o_sl_q, o_shl_a,
                 o_sub_a, o_add_a, o_busy, o_done, o_dbz};

  // Datapath driven by the controller's strobes.
  always @(posedge i_clk) begin
    if (o_clr_a) dp_a <= '0;
    if (o_ld_m)  dp_m <= divisor_bus;
    if (o_en_q)  dp_q <= dividend_bus;
    if (o_shl_a) dp_a <= {dp_a[WIDTH-1:0], dp_q[WIDTH-1]};
    if (o_sub_a) dp_a <= dp_a - {1'b0, dp_m};
    if (o_add_a) dp_a <= dp_a + {1'b0, dp_m};
    if (o_shl_q) dp_q <= {dp_q[WIDTH-2:0], o_sl_q};
  end

  // Reference: position within a run (-1 idle, 0 load, 1..3W rounds, LAST done).
  int m_pos = -1;
  bit m_dbz = 1'b0;
  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_pos <= -1;
      m_dbz <= 1'b0;
    end else if (m_pos < 0) begin
      if (i_start) begin
        if (i_divisor_zero) begin
          m_dbz <= 1'b1;
          m_pos <= LAST;
        end else begin
          m_pos <= 0;
        end
      end
    end else if (m_pos == 0) begin
      m_dbz <= 1'b0;
      m_pos <= 1;
    end else if (m_pos == LAST) begin
      m_pos <= -1;
    end else begin
      m_pos <= m_pos + 1;
    end
  end

  function automatic logic [10:0] model_out(int pos, bit dbz, logic msb);
    logic clr, ld, en, shlq, sl, shla, sub, add, busy, done;
    {clr, ld, en, shlq, sl, shla, sub, add, busy, done} = '0;
    if (pos >= 0) begin
      busy = 1'b1;
      if (pos == 0) {clr, ld, en} = 3'b111;
      else if (pos == LAST) done = 1'b1;
      else begin
        case ((pos - 1) % 3)
          0: shla = 1'b1;
          1: sub  = 1'b1;
          default: begin
            shlq = 1'b1;
            add  = msb;
            sl   = ~msb;
          end
        endcase
      end
    end
    return {clr, ld, en, shlq, sl, shla, sub, add, busy, done, dbz};
  endfunction

  // Strobe exclusivity monitor over the whole run.
  always @(negedge i_clk) begin
    if (i_rst === 1'b0) begin
      total++;
      if ((int'(o_shl_a) + int'(o_sub_a) + int'(o_add_a)) > 1 ||
          (o_en_q && o_shl_q) || (o_sl_q && !o_shl_q)) begin
        bad++;
        $display("FAIL exclusivity t=%0t got outs=%b required one-hot A op, no en_q&shl_q, sl_q only with shl_q",
                 $time, outs);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_start = 1'b1; i_divisor_zero = 1'b0;
    use_dp = 1'b0; msb_drv = 1'b0;
    dividend_bus = '0; divisor_bus = WIDTH'(1);
    tick(); tick();
    #1;
    total++;
    if (outs !== 11'b0) begin bad++; $display("FAIL reset_hold got=%b required=%b", outs, 11'b0); end
    i_start = 1'b0;
    i_rst = 1'b0;
    #1;
    total++;
    if (outs !== 11'b0) begin bad++; $display("FAIL reset_release got=%b required=%b", outs, 11'b0); end
    tick();
  endtask

  task automatic test_normal();
    int edges, it, done_edge;
    logic [WIDTH-1:0] sl_got, add_got;
    logic [10:0] exp;
    use_dp = 1'b1; dividend_bus = WIDTH'(13); divisor_bus = WIDTH'(3);
    i_divisor_zero = 1'b0; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    edges = 0; it = 0; done_edge = -1; sl_got = '0; add_got = '0;
    while (edges <= 3 * LAST) begin
      #1;
      exp = model_out(m_pos, m_dbz, i_a_msb);
      total++;
      if (outs !== exp) begin bad++; $display("FAIL normal_cycle edge=%0d got=%b required=%b", edges, outs, exp); end
      if (o_shl_q === 1'b1 && it < WIDTH) begin
        sl_got[it] = o_sl_q; add_got[it] = o_add_a; it++;
      end
      if (o_done === 1'b1) begin done_edge = edges; break; end
      tick(); edges++;
    end
    total++;
    if (done_edge != LAST) begin bad++; $display("FAIL normal_latency got=%0d required=%0d", done_edge, LAST); end
    total++;
    if (sl_got !== 4'b0010) begin bad++; $display("FAIL normal_sl_seq got=%b required=%b (iter4..1)", sl_got, 4'b0010); end
    total++;
    if (add_got !== 4'b1101) begin bad++; $display("FAIL normal_add_seq got=%b required=%b (iter4..1)", add_got, 4'b1101); end
    total++;
    if (dp_q !== WIDTH'(4)) begin bad++; $display("FAIL normal_quotient got=%0d required=4", dp_q); end
    total++;
    if (dp_a !== (WIDTH+1)'(1)) begin bad++; $display("FAIL normal_remainder got=%0d required=1", dp_a); end
    tick();
  endtask

  task automatic test_random_div();
    int edges, done_edge;
    logic [WIDTH-1:0] dvd, dvs;
    logic [10:0] exp;
    use_dp = 1'b1; i_divisor_zero = 1'b0;
    for (int n = 0; n < 12; n++) begin
      dvd = WIDTH'($urandom_range(0, 15));
      dvs = WIDTH'($urandom_range(1, 15));
      dividend_bus = dvd; divisor_bus = dvs;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      edges = 0; done_edge = -1;
      while (edges <= 3 * LAST) begin
        #1;
        exp = model_out(m_pos, m_dbz, i_a_msb);
        total++;
        if (outs !== exp) begin bad++; $display("FAIL div_cycle %0d/%0d edge=%0d got=%b required=%b", dvd, dvs, edges, outs, exp); end
        if (o_done === 1'b1) begin done_edge = edges; break; end
        tick(); edges++;
      end
      total++;
      if (done_edge != LAST) begin bad++; $display("FAIL div_latency %0d/%0d got=%0d required=%0d", dvd, dvs, done_edge, LAST); end
      total++;
      if (dp_q !== dvd / dvs) begin bad++; $display("FAIL div_quotient %0d/%0d got=%0d required=%0d", dvd, dvs, dp_q, dvd / dvs); end
      total++;
      if (dp_a !== {1'b0, dvd % dvs}) begin bad++; $display("FAIL div_remainder %0d/%0d got=%0d required=%0d", dvd, dvs, dp_a, dvd % dvs); end
      tick();
    end
  endtask

  task automatic test_dbz();
    int nstrobe;
    use_dp = 1'b0; msb_drv = 1'b0;
    i_divisor_zero = 1'b1; i_start = 1'b1;
    tick();
    i_start = 1'b0; i_divisor_zero = 1'b0;
    #1;
    nstrobe = int'(o_en_q) + int'(o_ld_m) + int'(o_shl_q) + int'(o_clr_a);
    total++;
    if ({o_done, o_dbz, o_busy} !== 3'b111) begin bad++; $display("FAIL dbz_done got done,dbz,busy=%b required=111", {o_done, o_dbz, o_busy}); end
    tick(); #1;
    nstrobe += int'(o_en_q) + int'(o_ld_m) + int'(o_shl_q) + int'(o_clr_a);
    total++;
    if ({o_busy, o_done, o_dbz} !== 3'b001) begin bad++; $display("FAIL dbz_idle got busy,done,dbz=%b required=001", {o_busy, o_done, o_dbz}); end
    total++;
    if (nstrobe != 0) begin bad++; $display("FAIL dbz_no_strobes got=%0d required=0", nstrobe); end
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      total++;
      if (o_dbz !== 1'b1) begin bad++; $display("FAIL dbz_sticky cycle=%0d got=%b required=1", k, o_dbz); end
    end
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    #1;
    total++;
    if (o_ld_m !== 1'b1) begin bad++; $display("FAIL dbz_restart_load got ld_m=%b required=1", o_ld_m); end
    tick(); #1;
    total++;
    if (o_dbz !== 1'b0) begin bad++; $display("FAIL dbz_clear got=%b required=0", o_dbz); end
    for (int k = 0; k < 3 * LAST && o_busy === 1'b1; k++) tick();
  endtask

  task automatic test_busy_guard();
    int e, busy_cycles;
    logic [10:0] exp;
    use_dp = 1'b0; i_divisor_zero = 1'b0; i_start = 1'b1;
    tick();
    e = 0; busy_cycles = 0;
    while (e < 3 * LAST) begin
      msb_drv = 1'($urandom_range(0, 1));
      i_start = (e >= 4 && e <= 6);
      #1;
      exp = model_out(m_pos, m_dbz, i_a_msb);
      total++;
      if (outs !== exp) begin bad++; $display("FAIL guard_cycle edge=%0d got=%b required=%b", e, outs, exp); end
      if (o_busy !== 1'b1) break;
      busy_cycles++;
      tick(); e++;
    end
    i_start = 1'b0;
    total++;
    if (busy_cycles != LAST + 1) begin bad++; $display("FAIL guard_run_len got=%0d required=%0d", busy_cycles, LAST + 1); end
    tick();
  endtask

  task automatic test_back_to_back();
    int c, nd;
    int d[3];
    use_dp = 1'b0; i_divisor_zero = 1'b0; i_start = 1'b1;
    d[0] = -1; d[1] = -1; d[2] = -1;
    tick();
    c = 0; nd = 0;
    while (c < 60 && nd < 3) begin
      msb_drv = 1'($urandom_range(0, 1));
      #1;
      if (o_done === 1'b1) begin d[nd] = c; nd++; end
      tick(); c++;
    end
    i_start = 1'b0;
    total++;
    if (d[0] != LAST) begin bad++; $display("FAIL b2b_first got=%0d required=%0d", d[0], LAST); end
    total++;
    if (nd != 3 || d[1] - d[0] != LAST + 2) begin bad++; $display("FAIL b2b_period1 got=%0d required=%0d", d[1] - d[0], LAST + 2); end
    total++;
    if (nd != 3 || d[2] - d[1] != LAST + 2) begin bad++; $display("FAIL b2b_period2 got=%0d required=%0d", d[2] - d[1], LAST + 2); end
    for (int k = 0; k < 3 * LAST && o_busy === 1'b1; k++) tick();
    tick();
  endtask

  task automatic test_reset_mid();
    int e, done_edge;
    use_dp = 1'b1; dividend_bus = WIDTH'(13); divisor_bus = WIDTH'(3);
    i_divisor_zero = 1'b0; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (e = 0; e < 5; e++) tick();
    #1;
    total++;
    if (o_sub_a !== 1'b1) begin bad++; $display("FAIL rstmid_in_sub got sub_a=%b required=1", o_sub_a); end
    #1 i_rst = 1'b1;
    #1;
    total++;
    if (outs !== 11'b0) begin bad++; $display("FAIL rstmid_async got=%b required=%b", outs, 11'b0); end
    total++;
    if (o_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b required=0", o_busy); end
    tick();
    i_rst = 1'b0;
    #1;
    total++;
    if (outs !== 11'b0) begin bad++; $display("FAIL rstmid_release got=%b required=%b", outs, 11'b0); end
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    e = 0; done_edge = -1;
    while (e <= 3 * LAST) begin
      #1;
      if (o_done === 1'b1) begin done_edge = e; break; end
      tick(); e++;
    end
    total++;
    if (done_edge != LAST) begin bad++; $display("FAIL rstmid_rerun_latency got=%0d required=%0d", done_edge, LAST); end
    total++;
    if (dp_q !== WIDTH'(4)) begin bad++; $display("FAIL rstmid_rerun_quotient got=%0d required=4", dp_q); end
    tick();
  endtask

  task automatic test_random_msb();
    logic [10:0] exp;
    use_dp = 1'b0;
    for (int c = 0; c < 300; c++) begin
      i_start        = ($urandom_range(0, 3) == 0);
      i_divisor_zero = ($urandom_range(0, 3) == 0);
      msb_drv        = 1'($urandom_range(0, 1));
      #1;
      exp = model_out(m_pos, m_dbz, i_a_msb);
      total++;
      if (outs !== exp) begin bad++; $display("FAIL random_cycle c=%0d got=%b required=%b", c, outs, exp); end
      tick();
    end
    i_start = 1'b0;
    for (int k = 0; k < 3 * LAST && o_busy === 1'b1; k++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_normal();
    test_random_div();
    test_dbz();
    test_busy_guard();
    test_back_to_back();
    test_reset_mid();
    test_random_msb();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
